spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/shared_pkg.sv | 22 ++
 rtl/spi_master_shifter.sv | 40 ++++
 rtl/spi_master.sv | 172 +++++++++++++++++
 tb/tb_spi_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared SPI master definitions: FSM state encoding, command codes and the
// default read-data turnaround.
package shared_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        CMD,
        SHIFT,
        WAIT,
        CAPTURE,
        END
    } master_state_e;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    localparam int RD_WAIT_DEFAULT = 2;

endpackage

// File: rtl/spi_master_shifter.sv
// 10-bit shift register: parallel load for the outgoing command, MSB-first
// shift with serial input so the same register also collects the read byte.
module spi_master_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [9:0] load_data,
    input  logic       shift_en,
    input  logic       serial_in,
    output logic       serial_out,
    output logic       next_out,
    output logic [7:0] capture_next
);

    logic [9:0] sh_q;
    logic [9:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_data;
        end else if (shift_en) begin
            sh_d = {sh_q[8:0], serial_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign serial_out   = sh_q[9];
    assign next_out     = sh_q[8];
    // Low byte as it will look after the shift in progress completes.
    assign capture_next = {sh_q[6:0], serial_in};

endmodule

// File: rtl/spi_master.sv
// SPI master: sends a 10-bit command MSB first and, for rd-data commands,
// waits RD_WAIT cycles and captures one byte from MISO.
module spi_master
    import shared_pkg::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] cmd_data,
    input  logic       MISO,
    output logic       SS_n,
    output logic       MOSI,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

    master_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    cmd_q, cmd_d;
    logic          ss_n_q, ss_n_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic          sh_load;
    logic          sh_shift;
    logic          sh_msb;
    logic          sh_next;
    logic [7:0]    sh_capture;

    spi_master_shifter u_shifter (
        .clk          (clk),
        .rst          (rst),
        .load         (sh_load),
        .load_data    (cmd_data),
        .shift_en     (sh_shift),
        .serial_in    (MISO),
        .serial_out   (sh_msb),
        .next_out     (sh_next),
        .capture_next (sh_capture)
    );

    // Outputs are computed for the state being entered so the registered
    // values line up with state_q without any decode glitches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        ss_n_d     = 1'b0;
        mosi_d     = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;

        case (state_q)
            IDLE: begin
                ss_n_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d = SEL;
                    cnt_d   = '0;
                    cmd_d   = cmd_data[9:8];
                    sh_load = 1'b1;
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SEL: begin
                state_d = CMD;
                cnt_d   = '0;
                mosi_d  = sh_msb;
            end
            CMD: begin
                state_d = SHIFT;
                cnt_d   = '0;
                mosi_d  = sh_msb;
            end
            SHIFT: begin
                if (cnt_q == 4'd9) begin
                    cnt_d = '0;
                    if (cmd_q == RD_DATA) begin
                        state_d = WAIT;
                    end else begin
                        state_d = END;
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + 4'd1;
                    sh_shift = 1'b1;
                    mosi_d   = sh_next;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAPTURE: begin
                sh_shift = 1'b1;
                if (cnt_q == 4'd7) begin
                    state_d    = END;
                    cnt_d      = '0;
                    ss_n_d     = 1'b1;
                    done_d     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = sh_capture;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            END: begin
                state_d = IDLE;
                cnt_d   = '0;
                ss_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ss_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table of frames plus hand sequences, with a slave
// model on MISO and a scoreboard checked at every done pulse.
module tb_spi_master;

    localparam int RD_WAIT = 2;

    typedef struct {
        logic [9:0]  cmd;
        logic [7:0]  miso;
        logic [11:0] mosi;
        int          low;
        logic        rv;
        logic [7:0]  rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] cmd_data;
    logic       MISO = 1'b1;
    logic       SS_n;
    logic       MOSI;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic [7:0] slave_byte = 8'h00;
    vec_t       exp_q[$];
    vec_t       tv[8];

    int          lo_cnt = 0;
    int          hi_cnt = 0;
    int          extra_ones = 0;
    logic [11:0] mosi_acc = '0;
    bit          seen_frame = 0;

    spi_master #(.RD_WAIT(RD_WAIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd_data (cmd_data),
        .MISO     (MISO),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%h t=%0t", name, act, $time);
        end
    endtask

    function automatic vec_t make_exp(input logic [9:0] cmd, input logic [7:0] miso,
                                      input logic [7:0] prev_rd);
        vec_t e;
        bit   is_rd;
        is_rd  = (cmd[9:8] == 2'b11);
        e.cmd  = cmd;
        e.miso = miso;
        e.mosi = {1'b0, cmd[9], cmd};
        e.low  = is_rd ? (12 + RD_WAIT + 8) : 12;
        e.rv   = is_rd;
        e.rd   = is_rd ? miso : prev_rd;
        return e;
    endfunction

    // Slave model and scoreboard, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            lo_cnt     = 0;
            mosi_acc   = '0;
            extra_ones = 0;
            MISO       = 1'b1;
        end else begin
            if (!SS_n) begin
                if (lo_cnt == 0 && seen_frame) begin
                    chk("ss_gap_ge2", 32'(hi_cnt >= 2), 32'd1);
                end
                hi_cnt = 0;
                lo_cnt++;
                if (lo_cnt <= 12) mosi_acc = {mosi_acc[10:0], MOSI};
                else if (MOSI) extra_ones++;
                if (lo_cnt >= 13 + RD_WAIT && lo_cnt <= 20 + RD_WAIT)
                    MISO = slave_byte[7 - (lo_cnt - 13 - RD_WAIT)];
                else
                    MISO = 1'b1;
            end else begin
                MISO = 1'b1;
                hi_cnt++;
                if (done) begin
                    chk("expect_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        vec_t e;
                        e = exp_q.pop_front();
                        chk("frame_mosi", 32'(mosi_acc), 32'(e.mosi));
                        chk("frame_ss_low_cycles", 32'(lo_cnt), 32'(e.low));
                        chk("frame_rd_valid", 32'(rd_valid), 32'(e.rv));
                        chk("frame_rd_data", 32'(rd_data), 32'(e.rd));
                        chk("frame_mosi_idle_zero", 32'(extra_ones), 32'd0);
                        chk("frame_busy_at_end", 32'(busy), 32'd1);
                    end
                    seen_frame = 1;
                    done_cnt++;
                end
                lo_cnt     = 0;
                mosi_acc   = '0;
                extra_ones = 0;
            end
            if (rd_valid && !done) chk("rd_valid_needs_done", 32'(done), 32'd1);
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 80 && done_cnt < target; i++) @(negedge clk);
        chk("done_within_bound", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        int d0;
        d0         = done_cnt;
        cmd_data   = v.cmd;
        slave_byte = v.miso;
        exp_q.push_back(v);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done(d0 + 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0;
        tv[0] = '{10'h0AB, 8'h00, 12'h0AB, 12, 1'b0, 8'h00};
        tv[1] = '{10'h155, 8'h00, 12'h155, 12, 1'b0, 8'h00};
        tv[2] = '{10'h2C3, 8'h00, 12'h6C3, 12, 1'b0, 8'h00};
        tv[3] = '{10'h300, 8'hA5, 12'h700, 22, 1'b1, 8'hA5};
        tv[4] = '{10'h0FF, 8'h00, 12'h0FF, 12, 1'b0, 8'hA5};
        tv[5] = '{10'h3FF, 8'h3C, 12'h7FF, 22, 1'b1, 8'h3C};
        tv[6] = '{10'h3E0, 8'hFF, 12'h7E0, 22, 1'b1, 8'hFF};
        tv[7] = '{10'h000, 8'h00, 12'h000, 12, 1'b0, 8'hFF};

        rst      = 1'b1;
        start    = 1'b0;
        cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_ss_n", 32'(SS_n), 32'd1);
        chk("reset_mosi", 32'(MOSI), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_frame(tv[i]);

        // start and cmd_data disturbed during SHIFT must not affect the frame
        d0         = done_cnt;
        cmd_data   = 10'h155;
        slave_byte = 8'h00;
        exp_q.push_back(make_exp(10'h155, 8'h00, 8'hFF));
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        repeat (5) @(negedge clk);
        start      = 1'b1;
        cmd_data   = 10'h1FF;
        repeat (2) @(negedge clk);
        start      = 1'b0;
        wait_done(d0 + 1);
        repeat (20) @(negedge clk);
        chk("midframe_no_second_frame", 32'(done_cnt), 32'(d0 + 1));
        chk("midframe_idle_busy", 32'(busy), 32'd0);

        // asynchronous reset in the fifth SHIFT cycle aborts the frame
        d0       = done_cnt;
        cmd_data = 10'h0AB;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ss_n_immediate", 32'(SS_n), 32'd1);
        chk("abort_busy_immediate", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_rd_data_cleared", 32'(rd_data), 32'h00);
        run_frame(make_exp(10'h3AA, 8'h5A, 8'h00));

        // start held high across three back-to-back frames
        d0         = done_cnt;
        cmd_data   = 10'h2C3;
        slave_byte = 8'h00;
        for (int i = 0; i < 3; i++) exp_q.push_back(make_exp(10'h2C3, 8'h00, 8'h5A));
        start = 1'b1;
        for (int i = 0; i < 200 && done_cnt < d0 + 3; i++) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_start_three_done", 32'(done_cnt), 32'(d0 + 3));
        chk("held_start_idle_busy", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
